// File: rtl/cv_pkg.sv
// Shared CV-frame types: word width, frame size, scheduler state encoding and word reset value.
package cv_pkg;
    localparam int CV_WIDTH     = 16;
    localparam int NUM_CV_WORDS = 5;

    typedef logic [CV_WIDTH-1:0] cv_word_t;

    localparam cv_word_t CV_RESET = '0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2
    } cv_state_e;
endpackage

// File: rtl/cv_flag_sync.sv
// Two-flop synchroniser for an asynchronous level flag, plus a third flop for rise detection.
module cv_flag_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flag_i,
    output logic level_o,
    output logic rise_o
);
    logic [2:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], flag_i};
        end
    end

    assign level_o = sync_q[1];
    assign rise_o  = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/cv_frame_scheduler.sv
// Captures CV frames from the SPI receiver, holds them pending and applies them only on a
// sample-start strobe; a watchdog flags a link that has stopped delivering frames.
module cv_frame_scheduler
    import cv_pkg::*;
#(
    parameter int NUM_WORDS      = NUM_CV_WORDS,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 262144
) (
    input  logic                i_Clock,
    input  logic                i_Reset_N,
    input  logic                i_Frame_Done,
    input  logic [CV_WIDTH-1:0] i_Data0,
    input  logic [CV_WIDTH-1:0] i_Data1,
    input  logic [CV_WIDTH-1:0] i_Data2,
    input  logic [CV_WIDTH-1:0] i_Data3,
    input  logic [CV_WIDTH-1:0] i_Data4,
    input  logic                i_Sample_Start,
    output logic [CV_WIDTH-1:0] o_CV0,
    output logic [CV_WIDTH-1:0] o_CV1,
    output logic [CV_WIDTH-1:0] o_CV2,
    output logic [CV_WIDTH-1:0] o_CV3,
    output logic [CV_WIDTH-1:0] o_CV4,
    output logic                o_Update,
    output logic                o_Stale,
    output logic [7:0]          o_Overrun_Count,
    output cv_state_e           o_State
);
    localparam int              WD_W        = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WD_W-1:0] WD_MAX      = WD_W'(TIMEOUT_CYCLES);
    localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    cv_word_t        data_w      [NUM_WORDS];
    cv_word_t        pend_data_q [NUM_WORDS];
    cv_word_t        cv_q        [NUM_WORDS];
    logic            flag_level;
    logic            flag_rise;
    cv_state_e       state_q;
    logic [3:0]      settle_q;
    logic            pend_q;
    logic            update_q;
    logic            stale_q;
    logic [7:0]      ovr_q;
    logic [WD_W-1:0] wdog_q;
    logic [WD_W-1:0] wdog_d;
    logic            capture;
    logic            apply;

    assign data_w[0] = i_Data0;
    assign data_w[1] = i_Data1;
    assign data_w[2] = i_Data2;
    assign data_w[3] = i_Data3;
    assign data_w[4] = i_Data4;

    cv_flag_sync u_flag_sync (
        .clk_i   (i_Clock),
        .rst_ni  (i_Reset_N),
        .flag_i  (i_Frame_Done),
        .level_o (flag_level),
        .rise_o  (flag_rise)
    );

    // The settle window lets the receiver's unsynchronised data words become stable.
    always_ff @(posedge i_Clock or negedge i_Reset_N) begin
        if (!i_Reset_N) begin
            state_q  <= ST_IDLE;
            settle_q <= 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (flag_rise) begin
                        state_q  <= ST_SETTLE;
                        settle_q <= 4'd0;
                    end
                end
                ST_SETTLE: begin
                    if (!flag_level) begin
                        state_q <= ST_IDLE;
                    end else if (settle_q == SETTLE_LAST) begin
                        state_q <= ST_CAPTURE;
                    end else begin
                        settle_q <= settle_q + 4'd1;
                    end
                end
                ST_CAPTURE: state_q <= ST_IDLE;
                default:    state_q <= ST_IDLE;
            endcase
        end
    end

    assign capture = (state_q == ST_CAPTURE);
    assign apply   = i_Sample_Start & pend_q;
    assign wdog_d  = wdog_q + 1'b1;

    // A capture coinciding with an apply swaps the pending frame without counting an overrun.
    always_ff @(posedge i_Clock or negedge i_Reset_N) begin
        if (!i_Reset_N) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                pend_data_q[i] <= CV_RESET;
                cv_q[i]        <= CV_RESET;
            end
            pend_q   <= 1'b0;
            update_q <= 1'b0;
            stale_q  <= 1'b0;
            ovr_q    <= 8'd0;
            wdog_q   <= '0;
        end else begin
            update_q <= apply;
            if (apply) begin
                for (int i = 0; i < NUM_WORDS; i++) cv_q[i] <= pend_data_q[i];
            end
            if (capture) begin
                for (int i = 0; i < NUM_WORDS; i++) pend_data_q[i] <= data_w[i];
                pend_q <= 1'b1;
                if (pend_q && !i_Sample_Start && ovr_q != 8'hFF) begin
                    ovr_q <= ovr_q + 8'd1;
                end
                wdog_q  <= '0;
                stale_q <= 1'b0;
            end else begin
                if (apply) pend_q <= 1'b0;
                if (wdog_q != WD_MAX) begin
                    wdog_q <= wdog_d;
                    if (wdog_d == WD_MAX) stale_q <= 1'b1;
                end
            end
        end
    end

    assign o_CV0           = cv_q[0];
    assign o_CV1           = cv_q[1];
    assign o_CV2           = cv_q[2];
    assign o_CV3           = cv_q[3];
    assign o_CV4           = cv_q[4];
    assign o_Update        = update_q;
    assign o_Stale         = stale_q;
    assign o_Overrun_Count = ovr_q;
    assign o_State         = state_q;
endmodule

// File: tb/tb_cv_frame_scheduler.sv
// Self-checking bench for cv_frame_scheduler: directed vector table, corner sequences and a
// randomized run compared every cycle against a frame-level reference model.
module tb_cv_frame_scheduler;
    import cv_pkg::*;

    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 64;
    localparam int LATENCY = 3 + SETTLE + 1;

    typedef struct {
        logic [79:0] data;
        int          hold;
        logic        exp_upd;
        logic [79:0] exp_cv;
    } vec_t;

    typedef struct {
        int          at;
        logic [79:0] data;
    } cap_t;

    // clock / reset
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flag = 1'b0;
    logic        ss = 1'b0;
    logic [79:0] data_bus = '0;
    logic [15:0] cv0, cv1, cv2, cv3, cv4;
    logic        upd, stale;
    logic [7:0]  ovr;
    cv_state_e   state;
    wire  [79:0] cv_all = {cv0, cv1, cv2, cv3, cv4};

    always #5 clk = ~clk;

    cv_frame_scheduler #(
        .NUM_WORDS      (5),
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .i_Clock         (clk),
        .i_Reset_N       (rst_n),
        .i_Frame_Done    (flag),
        .i_Data0         (data_bus[79:64]),
        .i_Data1         (data_bus[63:48]),
        .i_Data2         (data_bus[47:32]),
        .i_Data3         (data_bus[31:16]),
        .i_Data4         (data_bus[15:0]),
        .i_Sample_Start  (ss),
        .o_CV0           (cv0),
        .o_CV1           (cv1),
        .o_CV2           (cv2),
        .o_CV3           (cv3),
        .o_CV4           (cv4),
        .o_Update        (upd),
        .o_Stale         (stale),
        .o_Overrun_Count (ovr),
        .o_State         (state)
    );

    // scoreboard
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    bit          chk_en  = 1'b0;
    bit          rnd_strb = 1'b0;
    cap_t        exp_q[$];
    logic [79:0] m_cv = '0;
    logic [79:0] m_pdat = '0;
    bit          m_pend = 1'b0;
    bit          m_upd = 1'b0;
    bit          m_stale = 1'b0;
    int          m_ovr = 0;
    int          m_wd = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_cv = '0; m_pdat = '0; m_pend = 0; m_upd = 0; m_stale = 0; m_ovr = 0; m_wd = 0;
    endtask

    // Frame-level reference: captures happen LATENCY edges after the flag is raised.
    always @(posedge clk) begin
        bit          cap;
        bit          had;
        logic [79:0] nd;
        cyc++;
        if (!rst_n) begin
            model_clear();
        end else begin
            cap = 0;
            nd  = '0;
            if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
                cap = 1;
                nd  = exp_q[0].data;
                void'(exp_q.pop_front());
            end
            had   = m_pend;
            m_upd = ss && had;
            if (m_upd) m_cv = m_pdat;
            if (cap) begin
                if (had && !ss && m_ovr < 255) m_ovr++;
                m_pdat  = nd;
                m_pend  = 1;
                m_wd    = 0;
                m_stale = 0;
            end else begin
                if (m_upd) m_pend = 0;
                if (m_wd < TIMEOUT) m_wd++;
                if (m_wd >= TIMEOUT) m_stale = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            check("model", {38'd0, cv_all, upd, stale, ovr},
                  {38'd0, m_cv, m_upd, m_stale, 8'(m_ovr)});
        end
    end

    // driver tasks
    function automatic bit pick();
        return rnd_strb && ($urandom_range(0, 3) == 0);
    endfunction

    task automatic frame(input logic [79:0] d, input int hold);
        @(negedge clk);
        flag     = 1'b1;
        data_bus = d;
        if (hold >= SETTLE + 1) exp_q.push_back('{cyc + LATENCY, d});
        ss = pick();
        repeat (hold) begin
            @(negedge clk);
            ss = pick();
        end
        flag = 1'b0;
        repeat (4) begin
            @(negedge clk);
            ss = pick();
        end
        ss = 1'b0;
    endtask

    task automatic strobe();
        @(negedge clk);
        ss = 1'b1;
        @(negedge clk);
        ss = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_cv"}, {48'd0, cv_all}, 128'd0);
        check({tag, "_upd"}, {127'd0, upd}, 128'd0);
        check({tag, "_stale"}, {127'd0, stale}, 128'd0);
        check({tag, "_ovr"}, {120'd0, ovr}, 128'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "bench time limit");
    end

    initial begin
        vec_t        vecs[5];
        logic [79:0] a, b, c;
        int          s;

        vecs[0] = '{80'h1111_2222_3333_4444_5555, 10, 1'b1, 80'h1111_2222_3333_4444_5555};
        vecs[1] = '{80'hAAAA_BBBB_CCCC_DDDD_EEEE,  2, 1'b0, 80'h1111_2222_3333_4444_5555};
        vecs[2] = '{80'h0001_0002_0003_0004_0005, 12, 1'b1, 80'h0001_0002_0003_0004_0005};
        vecs[3] = '{80'hFFFF_FFFF_FFFF_FFFF_FFFF,  3, 1'b0, 80'h0001_0002_0003_0004_0005};
        vecs[4] = '{80'hDEAD_BEEF_CAFE_F00D_1234,  8, 1'b1, 80'hDEAD_BEEF_CAFE_F00D_1234};

        repeat (3) @(negedge clk);
        check_zero("reset");
        check("reset_state", {126'd0, state}, {126'd0, ST_IDLE});
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // directed vectors: frame, strobe 20 cycles later, single-cycle pulse
        for (int i = 0; i < 5; i++) begin
            frame(vecs[i].data, vecs[i].hold);
            repeat (20) @(negedge clk);
            strobe();
            check($sformatf("vec%0d_upd", i), {127'd0, upd}, {127'd0, vecs[i].exp_upd});
            check($sformatf("vec%0d_cv", i), {48'd0, cv_all}, {48'd0, vecs[i].exp_cv});
            check($sformatf("vec%0d_ovr", i), {120'd0, ovr}, 128'd0);
            @(negedge clk);
            check($sformatf("vec%0d_pulse", i), {127'd0, upd}, 128'd0);
        end

        // two frames, one strobe: latest wins, one overrun
        a = {$urandom, $urandom, 16'($urandom)};
        b = {$urandom, $urandom, 16'($urandom)};
        frame(a, 10);
        frame(b, 10);
        strobe();
        check("pair_cv", {48'd0, cv_all}, {48'd0, b});
        check("pair_ovr", {120'd0, ovr}, 128'd1);

        // capture of b coincides with a strobe while a is pending
        a = 80'h0A0A_1A1A_2A2A_3A3A_4A4A;
        b = 80'h0B0B_1B1B_2B2B_3B3B_4B4B;
        frame(a, 10);
        @(negedge clk);
        flag     = 1'b1;
        data_bus = b;
        s        = cyc;
        exp_q.push_back('{s + LATENCY, b});
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            ss = (i == LATENCY - 1);
            if (i == LATENCY) begin
                check("coinc_upd", {127'd0, upd}, 128'd1);
                check("coinc_cv", {48'd0, cv_all}, {48'd0, a});
                check("coinc_ovr", {120'd0, ovr}, 128'd1);
            end
        end
        flag = 1'b0;
        repeat (4) @(negedge clk);
        strobe();
        check("coinc_next_upd", {127'd0, upd}, 128'd1);
        check("coinc_next_cv", {48'd0, cv_all}, {48'd0, b});
        check("coinc_next_ovr", {120'd0, ovr}, 128'd1);

        // overrun saturation
        for (int i = 0; i < 300; i++) begin
            a = {$urandom, $urandom, 16'($urandom)};
            b = {$urandom, $urandom, 16'($urandom)};
            frame(a, 9);
            frame(b, 9);
            strobe();
        end
        check("sat_ovr", {120'd0, ovr}, 128'd255);
        check("sat_cv", {48'd0, cv_all}, {48'd0, b});

        // watchdog
        repeat (70) @(negedge clk);
        check("stale_set", {127'd0, stale}, 128'd1);
        check("stale_cv_hold", {48'd0, cv_all}, {48'd0, b});
        c = 80'hC0C0_C1C1_C2C2_C3C3_C4C4;
        frame(c, 10);
        check("stale_clr", {127'd0, stale}, 128'd0);
        repeat (40) @(negedge clk);
        check("stale_early", {127'd0, stale}, 128'd0);
        repeat (30) @(negedge clk);
        check("stale_again", {127'd0, stale}, 128'd1);
        strobe();
        check("stale_apply_cv", {48'd0, cv_all}, {48'd0, c});

        // randomized frames and strobes against the model
        rnd_strb = 1'b1;
        for (int i = 0; i < 60; i++) begin
            int holds[8] = '{1, 2, 3, 8, 9, 10, 11, 12};
            a = {$urandom, $urandom, 16'($urandom)};
            frame(a, holds[$urandom_range(0, 7)]);
            repeat ($urandom_range(0, 6)) begin
                @(negedge clk);
                ss = pick();
            end
            ss = 1'b0;
        end
        rnd_strb = 1'b0;

        // reset during SETTLE
        @(negedge clk);
        flag     = 1'b1;
        data_bus = 80'h7777_7777_7777_7777_7777;
        exp_q.push_back('{cyc + LATENCY, data_bus});
        repeat (4) @(negedge clk);
        check("settle_state", {126'd0, state}, {126'd0, ST_SETTLE});
        rst_n = 1'b0;
        flag  = 1'b0;
        model_clear();
        #1;
        check_zero("rst_settle");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        strobe();
        check("rst_settle_noupd", {127'd0, upd}, 128'd0);

        // reset with a frame pending
        frame(80'h8888_8888_8888_8888_8888, 10);
        @(negedge clk);
        rst_n = 1'b0;
        model_clear();
        #1;
        check_zero("rst_pend");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        strobe();
        check("rst_pend_noupd", {127'd0, upd}, 128'd0);
        check("rst_pend_cv", {48'd0, cv_all}, 128'd0);

        // first frame after reset behaves normally
        frame(80'h9999_AAAA_BBBB_CCCC_DDDD, 10);
        strobe();
        check("post_rst_upd", {127'd0, upd}, 128'd1);
        check("post_rst_cv", {48'd0, cv_all}, {48'd0, 80'h9999_AAAA_BBBB_CCCC_DDDD});
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
